// File: rtl/tfacc_axi_pkg.sv
// Shared types and constants for the AXI4 burst read path.
//   AXI_BURST_INCR / AXI_SIZE_16B / AXI_CACHE_DEF : fixed AR attribute encodings
//   beat_cnt_t : 24-bit beat counter type
//   rd_state_t : burst reader FSM states
//   burst_len  : beats in the next burst, limited by the remaining beat count,
//                the maximum burst length and the distance to the next 4 KB page
package tfacc_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
   localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

   typedef logic [23:0] beat_cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

   // page_beat is address bits [11:4], the beat index inside the 4 KB page.
   function automatic logic [8:0] burst_len(input beat_cnt_t  remaining,
                                            input logic [7:0] page_beat,
                                            input logic [8:0] max_burst);
      logic [8:0] len;
      logic [8:0] to_page;
      to_page = 9'd256 - {1'b0, page_beat};
      len     = max_burst;
      if (to_page < len) len = to_page;
      if (remaining < {15'd0, len}) len = remaining[8:0];
      return len;
   endfunction

endpackage

// File: rtl/rd_data_fifo.sv
// Synchronous FIFO with a registered output stage.
//   push/push_data : write side, one entry per cycle
//   pop            : consumer takes out_data this cycle (ignored when !out_valid)
//   out_valid/out_data : head entry, held in a register
//   count          : entries held, including the one in the output register
// An entry pushed into an empty FIFO bypasses the array and appears on
// out_valid one cycle after the push.
module rd_data_fifo #(
   parameter int WIDTH = 129,
   parameter int DEPTH = 512,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    mem_cnt_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_q;

   logic do_pop;
   logic load;
   logic mem_has;
   logic bypass;
   logic mem_wr;
   logic mem_rd;

   assign do_pop  = pop && out_valid_q;
   assign load    = !out_valid_q || do_pop;
   assign mem_has = (mem_cnt_q != '0);
   assign bypass  = load && !mem_has && push;
   assign mem_wr  = push && !bypass;
   assign mem_rd  = load && mem_has;

   always_ff @(posedge clk) begin
      if (mem_wr) mem[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         if (mem_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (mem_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         mem_cnt_q <= mem_cnt_q + CW'(mem_wr) - CW'(mem_rd);
         if (load) begin
            out_valid_q <= mem_has || push;
            if (mem_rd)    out_q <= mem[rd_ptr_q];
            else if (push) out_q <= push_data;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_q;
   assign count     = mem_cnt_q + CW'(out_valid_q);

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read master: reads cmd_beats 16-byte beats starting at cmd_addr and
// delivers them in address order on a valid/ready stream.
//   cmd_*    : command handshake (address, beat count)
//   M_AXI_AR*: read address channel, bursts never cross a 4 KB page
//   M_AXI_R* : read data channel, RREADY held high while busy
//   out_*    : data stream, out_last marks the final beat of the command
//   busy/done/err : status; err is sticky until the next command is accepted
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ISSUE | issuing AR bursts as FIFO credit allows
// ST_DRAIN | all ARs issued, waiting for the last beat to leave out_*
module axi_burst_reader
   import tfacc_axi_pkg::*;
#(
   parameter int ADDR_W     = 40,
   parameter int DATA_W     = 128,
   parameter int ID_W       = 4,
   parameter int MAX_BURST  = 256,
   parameter int FIFO_DEPTH = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [23:0]       cmd_beats,
   output logic [ID_W-1:0]   M_AXI_ARID,
   output logic [ADDR_W-1:0] M_AXI_ARADDR,
   output logic [7:0]        M_AXI_ARLEN,
   output logic [2:0]        M_AXI_ARSIZE,
   output logic [1:0]        M_AXI_ARBURST,
   output logic              M_AXI_ARLOCK,
   output logic [3:0]        M_AXI_ARCACHE,
   output logic [2:0]        M_AXI_ARPROT,
   output logic [3:0]        M_AXI_ARQOS,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   input  logic [ID_W-1:0]   M_AXI_RID,
   input  logic [DATA_W-1:0] M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP,
   input  logic              M_AXI_RLAST,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [8:0]     MAX_LEN = 9'(MAX_BURST);
   localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

   rd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   beat_cnt_t         remaining_q, remaining_d;
   logic [CW-1:0]     reserved_q;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     credit;
   logic [CW-1:0]     res_add;
   logic [CW-1:0]     res_sub;
   logic [8:0]        ar_len;
   logic              cmd_hs;
   logic              ar_hs;
   logic              r_hs;
   logic              pop;
   logic              err_q;
   logic              zero_done_q;
   logic [DATA_W:0]   fifo_q;
   logic              unused_bits;

   // R-side tracker: replays the AR burst split from the command so RLAST can
   // be checked without queueing burst lengths per outstanding AR.
   beat_cnt_t         r_left_q;
   logic [8:0]        r_burst_left_q;
   logic [7:0]        r_page_q;
   logic [8:0]        r_cur_len;
   logic [8:0]        r_burst_after;
   logic              r_exp_last;
   logic              r_cmd_last;

   assign unused_bits = ^{M_AXI_RID, cmd_addr[3:0]};

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign cmd_hs    = cmd_valid && cmd_ready;

   assign ar_len = burst_len(remaining_q, addr_q[11:4], MAX_LEN);
   assign credit = DEPTH_C - fifo_count - reserved_q;

   // Credit only grows while an AR waits, so ARVALID never drops before ARREADY.
   assign M_AXI_ARVALID = (state_q == ST_ISSUE) && (credit >= CW'(ar_len));
   assign M_AXI_ARID    = '0;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARLEN   = 8'(ar_len - 9'd1);
   assign M_AXI_ARSIZE  = AXI_SIZE_16B;
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = AXI_CACHE_DEF;
   assign M_AXI_ARPROT  = '0;
   assign M_AXI_ARQOS   = '0;
   assign ar_hs         = M_AXI_ARVALID && M_AXI_ARREADY;

   assign M_AXI_RREADY = busy;
   assign r_hs         = M_AXI_RVALID && M_AXI_RREADY;

   assign r_cur_len     = burst_len(r_left_q, r_page_q, MAX_LEN);
   assign r_burst_after = (r_burst_left_q == '0) ? r_cur_len - 9'd1 : r_burst_left_q - 9'd1;
   assign r_exp_last    = (r_burst_after == '0);
   assign r_cmd_last    = (r_left_q == beat_cnt_t'(1));

   assign res_add = ar_hs ? CW'(ar_len) : '0;
   assign res_sub = CW'(r_hs && (reserved_q != '0));

   rd_data_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (r_hs),
      .push_data ({r_cmd_last, M_AXI_RDATA}),
      .pop       (pop),
      .out_valid (out_valid),
      .out_data  (fifo_q),
      .count     (fifo_count)
   );

   assign out_data = fifo_q[DATA_W-1:0];
   assign out_last = out_valid && fifo_q[DATA_W];
   assign pop      = out_valid && out_ready;
   assign done     = zero_done_q || (pop && out_last && (state_q == ST_DRAIN));
   assign err      = err_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_hs) begin
               addr_d      = {cmd_addr[ADDR_W-1:4], 4'h0};
               remaining_d = cmd_beats;
               if (cmd_beats != '0) state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ar_hs) begin
               addr_d      = addr_q + ADDR_W'({ar_len, 4'h0});
               remaining_d = remaining_q - beat_cnt_t'(ar_len);
               if (remaining_d == '0) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && out_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         addr_q         <= '0;
         remaining_q    <= '0;
         reserved_q     <= '0;
         err_q          <= 1'b0;
         zero_done_q    <= 1'b0;
         r_left_q       <= '0;
         r_burst_left_q <= '0;
         r_page_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         reserved_q  <= reserved_q + res_add - res_sub;
         zero_done_q <= cmd_hs && (cmd_beats == '0);
         if (cmd_hs)
            err_q <= 1'b0;
         else if (r_hs && ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != r_exp_last)))
            err_q <= 1'b1;
         if (cmd_hs) begin
            r_left_q       <= cmd_beats;
            r_burst_left_q <= '0;
            r_page_q       <= cmd_addr[11:4];
         end else if (r_hs) begin
            if (r_left_q != '0) r_left_q <= r_left_q - beat_cnt_t'(1);
            r_burst_left_q <= r_burst_after;
            r_page_q       <= r_page_q + 8'd1;
         end
      end
   end

   // Credit accounting keeps the FIFO below full whenever data can arrive.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(M_AXI_RVALID && (fifo_count == DEPTH_C)));

endmodule

// File: tb/tb_axi_burst_reader.sv
module tb_axi_burst_reader;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [39:0]   cmd_addr;
   logic [23:0]   cmd_beats;
   logic [3:0]    M_AXI_ARID;
   logic [39:0]   M_AXI_ARADDR;
   logic [7:0]    M_AXI_ARLEN;
   logic [2:0]    M_AXI_ARSIZE;
   logic [1:0]    M_AXI_ARBURST;
   logic          M_AXI_ARLOCK;
   logic [3:0]    M_AXI_ARCACHE;
   logic [2:0]    M_AXI_ARPROT;
   logic [3:0]    M_AXI_ARQOS;
   logic          M_AXI_ARVALID;
   logic          M_AXI_ARREADY;
   logic [3:0]    M_AXI_RID;
   logic [127:0]  M_AXI_RDATA;
   logic [1:0]    M_AXI_RRESP;
   logic          M_AXI_RLAST;
   logic          M_AXI_RVALID;
   logic          M_AXI_RREADY;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_data;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [39:0] exp_ar_addr[$];
   int          exp_ar_len[$];

   axi_burst_reader dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_beats     (cmd_beats),
      .M_AXI_ARID    (M_AXI_ARID),
      .M_AXI_ARADDR  (M_AXI_ARADDR),
      .M_AXI_ARLEN   (M_AXI_ARLEN),
      .M_AXI_ARSIZE  (M_AXI_ARSIZE),
      .M_AXI_ARBURST (M_AXI_ARBURST),
      .M_AXI_ARLOCK  (M_AXI_ARLOCK),
      .M_AXI_ARCACHE (M_AXI_ARCACHE),
      .M_AXI_ARPROT  (M_AXI_ARPROT),
      .M_AXI_ARQOS   (M_AXI_ARQOS),
      .M_AXI_ARVALID (M_AXI_ARVALID),
      .M_AXI_ARREADY (M_AXI_ARREADY),
      .M_AXI_RID     (M_AXI_RID),
      .M_AXI_RDATA   (M_AXI_RDATA),
      .M_AXI_RRESP   (M_AXI_RRESP),
      .M_AXI_RLAST   (M_AXI_RLAST),
      .M_AXI_RVALID  (M_AXI_RVALID),
      .M_AXI_RREADY  (M_AXI_RREADY),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_cmd_ready"}, 128'(cmd_ready),     128'(1));
      check_val({tag, "_arvalid"},   128'(M_AXI_ARVALID), 128'(0));
      check_val({tag, "_rready"},    128'(M_AXI_RREADY),  128'(0));
      check_val({tag, "_out_valid"}, 128'(out_valid),     128'(0));
      check_val({tag, "_out_last"},  128'(out_last),      128'(0));
      check_val({tag, "_busy"},      128'(busy),          128'(0));
      check_val({tag, "_done"},      128'(done),          128'(0));
      check_val({tag, "_err"},       128'(err),           128'(0));
   endtask

   task automatic exp_ar(input logic [39:0] a, input int arlen);
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(arlen);
   endtask

   // One command end to end with an in-order AXI slave model; word at A = A.
   task automatic run_cmd(input logic [39:0] a, input int beats, input int stall,
                          input bit rnd, input bit bad_rlast, input bit exp_err,
                          input int abort_at);
      logic [39:0] base;
      logic [39:0] pend_addr[$];
      int          pend_len[$];
      int          rbeat, cyc, popped, n_ar, n_exp, dones, acc_cyc, first_ar;
      bit          accepted, finished, aborted, bad_done;
      bit          ar_hold, out_hold;
      logic [39:0] hold_addr;
      logic [7:0]  hold_len;
      logic [127:0] hold_data;
      logic        hold_last;
      base = {a[39:4], 4'h0};
      rbeat = 0; cyc = 0; popped = 0; n_ar = 0; dones = 0; acc_cyc = -1; first_ar = -1;
      n_exp = exp_ar_addr.size();
      accepted = 0; finished = 0; aborted = 0; bad_done = 0; ar_hold = 0; out_hold = 0;
      hold_addr = '0; hold_len = '0; hold_data = '0; hold_last = 1'b0;
      while (!finished && cyc < 6000) begin
         @(negedge clk);
         cmd_valid     = !accepted;
         cmd_addr      = a;
         cmd_beats     = 24'(beats);
         M_AXI_ARREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (pend_addr.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = 128'(pend_addr[0] + 40'(16 * rbeat));
            M_AXI_RLAST  = (rbeat == pend_len[0] - 1);
            if (bad_rlast && !bad_done && rbeat == 0) M_AXI_RLAST = !M_AXI_RLAST;
         end else begin
            M_AXI_RVALID = 1'b0;
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc >= stall);
         #4;
         if (abort_at > 0 && cyc == abort_at) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            check_reset("abort");
            rst = 1'b0;
            M_AXI_RVALID = 1'b0;
            aborted = 1;
            break;
         end
         if (cmd_valid && cmd_ready) begin
            accepted = 1;
            acc_cyc  = cyc;
         end
         if (M_AXI_ARVALID && first_ar < 0) first_ar = cyc;
         if (ar_hold) begin
            check_val("arvalid_hold", 128'(M_AXI_ARVALID), 128'(1));
            check_val("araddr_hold",  128'(M_AXI_ARADDR),  128'(hold_addr));
            check_val("arlen_hold",   128'(M_AXI_ARLEN),   128'(hold_len));
         end
         ar_hold   = M_AXI_ARVALID && !M_AXI_ARREADY;
         hold_addr = M_AXI_ARADDR;
         hold_len  = M_AXI_ARLEN;
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            n_ar++;
            if (exp_ar_addr.size() > 0) begin
               check_val("araddr", 128'(M_AXI_ARADDR), 128'(exp_ar_addr.pop_front()));
               check_val("arlen",  128'(M_AXI_ARLEN),  128'(exp_ar_len.pop_front()));
            end
            check_val("ar_4k", 128'((int'(M_AXI_ARADDR[11:4]) + int'(M_AXI_ARLEN) + 1) <= 256), 128'(1));
            check_val("ar_const",
                      128'({M_AXI_ARID, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
                            M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS}),
                      128'({4'h0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0}));
            pend_addr.push_back(M_AXI_ARADDR);
            pend_len.push_back(int'(M_AXI_ARLEN) + 1);
         end
         if (M_AXI_RVALID && M_AXI_RREADY) begin
            bad_done = 1;
            rbeat++;
            if (rbeat == pend_len[0]) begin
               void'(pend_addr.pop_front());
               void'(pend_len.pop_front());
               rbeat = 0;
            end
         end
         if (out_hold) begin
            check_val("out_valid_hold", 128'(out_valid), 128'(1));
            check_val("out_data_hold",  out_data,        hold_data);
            check_val("out_last_hold",  128'(out_last),  128'(hold_last));
         end
         out_hold  = out_valid && !out_ready;
         hold_data = out_data;
         hold_last = out_last;
         if (done) dones++;
         if (out_valid && out_ready) begin
            check_val("out_data", out_data, 128'(base + 40'(16 * popped)));
            check_val("out_last", 128'(out_last), 128'(popped == beats - 1));
            check_val("done_at_pop", 128'(done), 128'(popped == beats - 1));
            popped++;
         end
         if (stall > 0 && cyc == stall - 1) begin
            check_val("ars_while_stalled", 128'(n_ar), 128'(2));
            check_val("valid_while_stalled", 128'(out_valid), 128'(1));
         end
         cyc++;
         if (popped == beats) finished = 1;
      end
      if (!aborted) begin
         check_val("beats_delivered", 128'(popped), 128'(beats));
         check_val("ar_count", 128'(n_ar), 128'(n_exp));
         check_val("ar_latency", 128'(first_ar), 128'(acc_cyc + 1));
         check_val("done_count", 128'(dones), 128'(1));
         check_val("err", 128'(err), 128'(exp_err));
         @(negedge clk);
         M_AXI_RVALID = 1'b0;
         out_ready    = 1'b0;
         cmd_valid    = 1'b0;
         #4;
         check_val("idle_busy", 128'(busy), 128'(0));
         check_val("idle_cmd_ready", 128'(cmd_ready), 128'(1));
      end
      exp_ar_addr.delete();
      exp_ar_len.delete();
   endtask

   task automatic run_zero();
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = 40'h5000;
      cmd_beats = 24'd0;
      #4;
      check_val("zero_accept", 128'(cmd_ready), 128'(1));
      @(negedge clk);
      cmd_valid = 1'b0;
      #4;
      check_val("zero_done", 128'(done), 128'(1));
      check_val("zero_arvalid", 128'(M_AXI_ARVALID), 128'(0));
      check_val("zero_busy", 128'(busy), 128'(0));
      @(negedge clk);
      #4;
      check_val("zero_done_pulse", 128'(done), 128'(0));
      check_val("zero_arvalid2", 128'(M_AXI_ARVALID), 128'(0));
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
      M_AXI_ARREADY = 1'b0; M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
      M_AXI_RLAST = 1'b0; M_AXI_RVALID = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      @(negedge clk);
      rst = 1'b0;

      exp_ar(40'h1000, 15);
      run_cmd(40'h1000, 16, 0, 0, 0, 0, 0);

      exp_ar(40'h1F80, 7);
      exp_ar(40'h2000, 11);
      run_cmd(40'h1F80, 20, 0, 0, 0, 0, 0);

      exp_ar(40'h1000, 1);
      run_cmd(40'h1007, 2, 0, 0, 0, 0, 0);

      run_zero();

      exp_ar(40'h2000, 3);
      run_cmd(40'h2000, 4, 0, 0, 1, 1, 0);

      exp_ar(40'h0000, 255);
      exp_ar(40'h1000, 255);
      exp_ar(40'h2000, 87);
      run_cmd(40'h0, 600, 0, 0, 0, 0, 0);

      exp_ar(40'h0000, 255);
      exp_ar(40'h1000, 255);
      exp_ar(40'h2000, 87);
      run_cmd(40'h0, 600, 800, 0, 0, 0, 0);

      exp_ar(40'h0FC0, 3);
      exp_ar(40'h1000, 95);
      run_cmd(40'h0FC0, 100, 0, 1, 0, 0, 0);

      exp_ar(40'h0, 63);
      run_cmd(40'h0, 64, 0, 0, 0, 0, 20);

      exp_ar(40'h1000, 15);
      run_cmd(40'h1000, 16, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
